// File: rtl/serv_bufreg2_wide.sv
// Secondary buffer register for a W-bit-per-cycle serial core: store data, load data
// with sign/zero extension, shift-amount counting and bus byte selects.
module serv_bufreg2_wide #(
    parameter int W = 1,
    localparam int RW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_init,
    input  logic          i_cnt_done,
    input  logic [1:0]    i_lsb,
    input  logic          i_byte_valid,
    input  logic          i_op_b_sel,
    input  logic          i_shift_op,
    input  logic [W-1:0]  i_rs2,
    input  logic [W-1:0]  i_imm,
    input  logic [1:0]    i_ls_size,
    input  logic          i_ls_signed,
    input  logic          i_load,
    input  logic [31:0]   i_dat,
    output logic [W-1:0]  o_op_b,
    output logic [W-1:0]  o_q,
    output logic          o_sh_done,
    output logic          o_sh_done_r,
    output logic [RW-1:0] o_sh_rem,
    output logic [31:0]   o_dat,
    output logic [3:0]    o_sel
);

    logic [31:0] dat;
    logic [31:0] next_dat;
    logic [5:0]  sh_cnt;
    logic [4:0]  rd_ptr;
    logic        sh_done_r;
    logic        dat_en;
    logic        sh_load;
    logic        sh_step;
    logic        sh_low;
    logic [5:0]  size_bits;
    logic [4:0]  base;
    logic [4:0]  sign_idx;
    logic        ext_bit;
    logic [3:0]  sel_mask;

    assign o_op_b   = i_op_b_sel ? i_rs2 : i_imm;
    assign dat_en   = i_en & i_init & (i_shift_op | i_byte_valid);
    assign next_dat = {o_op_b, dat[31:W]};
    assign sh_load  = i_en & i_init & i_shift_op & i_cnt_done;
    assign sh_step  = i_en & ~i_init & i_shift_op;
    assign sh_low   = sh_cnt < 6'(W);

    // A bus load overrides any operand shift-in happening in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            dat <= '0;
        else if (i_load)
            dat <= i_dat;
        else if (dat_en)
            dat <= next_dat;
    end

    // Loaded with the shift amount as its last operand chunk arrives; saturates at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sh_cnt <= '0;
        else if (sh_load)
            sh_cnt <= {1'b0, next_dat[4:0]};
        else if (sh_step)
            sh_cnt <= sh_low ? 6'd0 : sh_cnt - 6'(W);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            sh_done_r <= 1'b0;
        else if (i_init)
            sh_done_r <= 1'b0;
        else
            sh_done_r <= o_sh_done;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            rd_ptr <= '0;
        else if (i_load || i_init)
            rd_ptr <= '0;
        else if (i_en && !i_shift_op)
            rd_ptr <= rd_ptr + 5'(W);
    end

    assign o_sh_done   = i_shift_op & ~i_init & sh_low;
    assign o_sh_done_r = sh_done_r;
    assign o_dat       = dat;

    generate
        if (W == 1) begin : g_rem_narrow
            assign o_sh_rem = '0;
        end else begin : g_rem_wide
            assign o_sh_rem = sh_low ? sh_cnt[RW-1:0] : '0;
        end
    endgenerate

    always_comb begin
        size_bits = 6'd32;
        sel_mask  = 4'b1111;
        case (i_ls_size)
            2'd0: begin
                size_bits = 6'd8;
                sel_mask  = 4'b0001;
            end
            2'd1: begin
                size_bits = 6'd16;
                sel_mask  = 4'b0011;
            end
            default: begin
                size_bits = 6'd32;
                sel_mask  = 4'b1111;
            end
        endcase
    end

    assign base     = {i_lsb, 3'b000};
    assign sign_idx = base + 5'(size_bits - 6'd1);
    assign ext_bit  = i_ls_signed & dat[sign_idx];
    assign o_sel    = sel_mask << i_lsb;

    // Each lane reads the aligned field in place; lanes past the field width get the extension bit.
    generate
        for (genvar j = 0; j < W; j++) begin : g_lane
            logic [5:0] pos;
            logic [4:0] idx;
            assign pos    = {1'b0, rd_ptr} + 6'(j);
            assign idx    = base + rd_ptr + 5'(j);
            assign o_q[j] = (pos < size_bits) ? dat[idx] : ext_bit;
        end
    endgenerate

endmodule

// File: tb/tb_serv_bufreg2_wide.sv
// Scoreboard bench for serv_bufreg2_wide: stimulus pushes expectations, a negedge monitor
// pops and compares them against the live DUT outputs.
module tb_serv_bufreg2_wide;

    localparam int W     = 4;
    localparam int RW    = (W > 1) ? $clog2(W) : 1;
    localparam int STEPS = 32 / W;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_en = 1'b0;
    logic          i_init = 1'b0;
    logic          i_cnt_done = 1'b0;
    logic [1:0]    i_lsb = '0;
    logic          i_byte_valid = 1'b0;
    logic          i_op_b_sel = 1'b0;
    logic          i_shift_op = 1'b0;
    logic [W-1:0]  i_rs2 = '0;
    logic [W-1:0]  i_imm = '0;
    logic [1:0]    i_ls_size = '0;
    logic          i_ls_signed = 1'b0;
    logic          i_load = 1'b0;
    logic [31:0]   i_dat = '0;
    logic [W-1:0]  o_op_b;
    logic [W-1:0]  o_q;
    logic          o_sh_done;
    logic          o_sh_done_r;
    logic [RW-1:0] o_sh_rem;
    logic [31:0]   o_dat;
    logic [3:0]    o_sel;

    serv_bufreg2_wide #(.W(W)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_init(i_init),
        .i_cnt_done(i_cnt_done), .i_lsb(i_lsb), .i_byte_valid(i_byte_valid),
        .i_op_b_sel(i_op_b_sel), .i_shift_op(i_shift_op), .i_rs2(i_rs2), .i_imm(i_imm),
        .i_ls_size(i_ls_size), .i_ls_signed(i_ls_signed), .i_load(i_load), .i_dat(i_dat),
        .o_op_b(o_op_b), .o_q(o_q), .o_sh_done(o_sh_done), .o_sh_done_r(o_sh_done_r),
        .o_sh_rem(o_sh_rem), .o_dat(o_dat), .o_sel(o_sel)
    );

    always #5 clk = ~clk;

    typedef enum int {K_OPB, K_Q, K_DONE, K_DONER, K_REM, K_DAT, K_SEL} kind_t;
    typedef struct {
        kind_t       kind;
        string       name;
        logic [31:0] exp;
        longint      cyc;
    } item_t;

    item_t       sb_q[$];
    int          n_total = 0;
    int          n_pass = 0;
    longint      cyc = 0;
    logic [31:0] m_dat = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input kind_t k);
        case (k)
            K_OPB:   return 32'(o_op_b);
            K_Q:     return 32'(o_q);
            K_DONE:  return 32'(o_sh_done);
            K_DONER: return 32'(o_sh_done_r);
            K_REM:   return 32'(o_sh_rem);
            K_DAT:   return o_dat;
            default: return 32'(o_sel);
        endcase
    endfunction

    task automatic compare(input item_t it);
        logic [31:0] act;
        act = actual(it.kind);
        n_total++;
        if (act === it.exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", it.name, act, it.exp, it.cyc);
    endtask

    task automatic drain();
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            item_t it;
            it = sb_q.pop_front();
            compare(it);
        end
    endtask

    always @(negedge clk) drain();

    task automatic expect_out(input kind_t k, input string name, input logic [31:0] v);
        item_t it;
        it.kind = k;
        it.name = name;
        it.exp  = v;
        it.cyc  = cyc;
        sb_q.push_back(it);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_en = 1'b0; i_init = 1'b0; i_cnt_done = 1'b0; i_byte_valid = 1'b0;
        i_shift_op = 1'b0; i_load = 1'b0;
    endtask

    function automatic logic [3:0] sel_model(input logic [1:0] size, input logic [1:0] lsb);
        logic [7:0] m;
        m = (size == 2'd0) ? 8'h1 : (size == 2'd1) ? 8'h3 : 8'hF;
        m = m << lsb;
        return m[3:0];
    endfunction

    // Whole-word view of the load: rotate the addressed field down, then zero/sign extend it.
    function automatic logic [31:0] load_result(input logic [31:0] d, input logic [1:0] lsb,
                                                input logic [1:0] size, input logic sgn);
        int          sb;
        logic [63:0] dd;
        logic [31:0] rot;
        logic [31:0] low;
        logic [31:0] r;
        sb  = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
        dd  = {d, d} >> (8 * int'(lsb));
        rot = dd[31:0];
        low = (sb == 32) ? 32'hFFFF_FFFF : ((32'd1 << sb) - 32'd1);
        r   = rot & low;
        if (sgn && rot[sb-1]) r = r | ~low;
        return r;
    endfunction

    task automatic do_store(input logic [31:0] rs2w, input logic [31:0] immw, input logic sel,
                            input logic [1:0] lsb, input logic [1:0] size, input bit rand_gate);
        logic [W-1:0] chunk;
        for (int k = 0; k < STEPS; k++) begin
            i_en         = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_byte_valid = rand_gate ? 1'($urandom_range(0, 1)) : 1'b1;
            i_init = 1'b1; i_shift_op = 1'b0; i_op_b_sel = sel;
            i_lsb = lsb; i_ls_size = size;
            i_rs2 = rs2w[k*W +: W];
            i_imm = immw[k*W +: W];
            chunk = sel ? i_rs2 : i_imm;
            expect_out(K_OPB, "op_b", 32'(chunk));
            if (i_en && i_byte_valid) m_dat = (m_dat >> W) | (32'(chunk) << (32 - W));
            step();
        end
        idle();
        expect_out(K_DAT, "store_dat", m_dat);
        expect_out(K_SEL, "store_sel", 32'(sel_model(size, lsb)));
        step();
    endtask

    task automatic do_shift(input logic [31:0] opw, input int exec_steps, input bit rand_gate,
                            input int reset_at);
        logic sel;
        int   rem;
        bit   done;
        bit   prev_done;
        sel = 1'($urandom_range(0, 1));
        for (int k = 0; k < STEPS; k++) begin
            i_en = 1'b1; i_init = 1'b1; i_shift_op = 1'b1; i_op_b_sel = sel;
            i_cnt_done   = (k == STEPS - 1);
            i_byte_valid = 1'($urandom_range(0, 1));
            i_rs2 = sel ? opw[k*W +: W] : W'($urandom);
            i_imm = sel ? W'($urandom) : opw[k*W +: W];
            m_dat = (m_dat >> W) | (32'(opw[k*W +: W]) << (32 - W));
            step();
        end
        rem = int'(opw[4:0]);
        prev_done = 1'b0;
        for (int k = 0; k < exec_steps; k++) begin
            i_init = 1'b0; i_cnt_done = 1'b0; i_shift_op = 1'b1;
            i_en = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (k == reset_at) begin
                #3;
                i_rst_n = 1'b0;
                m_dat = '0;
                expect_out(K_DAT, "rst_mid_dat", 32'd0);
                expect_out(K_DONER, "rst_mid_done_r", 32'd0);
                expect_out(K_REM, "rst_mid_rem", 32'd0);
                step();
                i_rst_n = 1'b1;
                idle();
                step();
                return;
            end
            done = (rem < W);
            expect_out(K_DONE, "sh_done", 32'(done));
            expect_out(K_DONER, "sh_done_r", 32'(prev_done));
            expect_out(K_REM, "sh_rem", (done && W > 1) ? 32'(rem) : 32'd0);
            expect_out(K_DAT, "sh_dat", m_dat);
            prev_done = done;
            if (i_en) rem = (rem >= W) ? rem - W : 0;
            step();
        end
        idle();
        step();
    endtask

    task automatic do_load(input logic [31:0] data, input logic [1:0] lsb, input logic [1:0] size,
                           input logic sgn, input bit collide, input bit rand_gate);
        logic [31:0] r;
        int          ptr;
        int          n;
        i_load = 1'b1; i_dat = data; i_lsb = lsb; i_ls_size = size; i_ls_signed = sgn;
        if (collide) begin
            i_en = 1'b1; i_init = 1'b1; i_byte_valid = 1'b1; i_shift_op = 1'b0;
            i_rs2 = W'($urandom); i_imm = W'($urandom);
        end
        m_dat = data;
        step();
        idle();
        expect_out(K_DAT, "load_dat", m_dat);
        expect_out(K_SEL, "load_sel", 32'(sel_model(size, lsb)));
        r   = load_result(data, lsb, size, sgn);
        ptr = 0;
        n   = rand_gate ? STEPS + 4 : STEPS;
        for (int k = 0; k < n; k++) begin
            i_en = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
            i_init = 1'b0; i_shift_op = 1'b0;
            expect_out(K_Q, "load_q", (r >> ptr) & ((32'd1 << W) - 32'd1));
            if (i_en) ptr = (ptr + W) % 32;
            step();
        end
        idle();
        step();
    endtask

    initial begin
        idle();
        i_rst_n = 1'b0;
        step();
        expect_out(K_DAT, "reset_dat", 32'd0);
        expect_out(K_DONER, "reset_done_r", 32'd0);
        expect_out(K_REM, "reset_rem", 32'd0);
        step();
        i_rst_n = 1'b1;
        step();

        do_store(32'hA5A5_1234, 32'h0, 1'b1, 2'd0, 2'd2, 1'b0);
        do_shift(32'h0000_000D, 6, 1'b0, -1);
        do_load(32'h0000_8000, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0);
        do_load(32'hBEEF_0000, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
        do_shift(32'h0000_001F, 8, 1'b0, 4);
        do_shift(32'hFFFF_FFE0, 3, 1'b0, -1);
        do_load(32'h1357_9BDF, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0);

        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 2))
                0: do_store($urandom, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                            2'($urandom_range(0, 3)), 1'b1);
                1: do_shift($urandom, 10, 1'b1, -1);
                default: do_load($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            endcase
        end

        repeat (3) step();
        while (sb_q.size() > 0) begin
            item_t it;
            it = sb_q.pop_front();
            n_total++;
            $display("[TB] FAIL %s: never compared, expected 0x%08h", it.name, it.exp);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serv_bufreg2_wide.md
Name: serv_bufreg2_wide

Overview:
- Parametrised successor of the bit-serial secondary buffer register used for store data, load data and shift counting.
- Generalised to a W-bit-per-cycle datapath.
- Adds a dedicated shift down-counter that reports a sub-W residual.
- Adds load sign/zero extension for byte, half and word sizes.
- Adds byte-select generation for the external bus.
- Sits between the decoder/ALU operand path and the memory interface.

Parameters:
- W, 1: bits processed per enabled cycle. Legal values are 1, 2, 4 and 8.
- RW, (W>1 ? log2(W) : 1): width of o_sh_rem. Derived; do not override.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_en  in  1  serial step enable.
- i_init  in  1  init phase: operand shift-in.
- i_cnt_done  in  1  last step of the current phase.
- i_lsb  in  2  address byte offset.
- i_byte_valid  in  1  store data alignment window is open.
- i_op_b_sel  in  1  1 selects rs2, 0 selects imm.
- i_shift_op  in  1  current op is a shift.
- i_rs2  in  W  serial rs2 chunk.
- i_imm  in  W  serial immediate chunk.
- i_ls_size  in  2  load/store size: 0 = byte, 1 = half, 2 = word.
- i_ls_signed  in  1  sign-extend loads.
- i_load  in  1  capture i_dat (bus ack).
- i_dat  in  32  bus read data.
- o_op_b  out  W  selected operand B chunk.
- o_q  out  W  extended load-result chunk.
- o_sh_done  out  1  shift count exhausted (combinational).
- o_sh_done_r  out  1  registered copy of o_sh_done.
- o_sh_rem  out  RW  residual shift amount, less than W.
- o_dat  out  32  data register to the bus.
- o_sel  out  4  byte selects.

Behaviour:

Reset:
- i_rst_n low asynchronously clears dat[31:0], sh_cnt[5:0], rd_ptr[4:0] and sh_done_r.
- Consequences: o_dat = 0, o_sh_done_r = 0, o_sh_rem = 0.
- Reset mid-operation aborts the operation. No partial state survives.

Operand and store path:
- o_op_b = i_op_b_sel ? i_rs2 : i_imm.
- dat_en = i_en & i_init & (i_shift_op | i_byte_valid).
- Register update, in priority order:
  - i_load: dat <= i_dat.
  - else if dat_en: dat <= {o_op_b, dat[31:W]}, filling LSB-first.
- o_dat = dat.
- For a word store with i_lsb = 0, rs2 lands exactly in dat after 32/W enabled init steps.
- Alignment for other offsets comes from i_byte_valid gating.

Shift counter:
- Load: on an i_en & i_init & i_shift_op & i_cnt_done cycle, sh_cnt <= {1'b0, next_dat[4:0]}.
  - next_dat[4:0] equals dat[4+W:W], i.e. operand bits 4:0.
- Count: each i_en & !i_init & i_shift_op cycle, sh_cnt <= sh_cnt - W, saturating at 0.
- o_sh_done = i_shift_op & !i_init & (sh_cnt < W).
- o_sh_done_r <= o_sh_done on every clock. It is cleared when i_init is high.
- o_sh_rem = sh_cnt[RW-1:0] when sh_cnt < W, else 0. It is 0 when W = 1.
- shamt = 0 gives o_sh_done on the first execute cycle.

Load readout:
- rd_ptr is cleared when i_load = 1 or i_init = 1.
- Otherwise rd_ptr += W (mod 32) on each i_en & !i_init & !i_shift_op cycle.
- Size in bits: sb = 8, 16 or 32 for i_ls_size = 0, 1 or 2. i_ls_size = 3 is treated as a word.
- Base offset: base = 8*i_lsb.
- Sign bit: s = dat[(base+sb-1) mod 32].
- For each lane j in 0..W-1:
  - If rd_ptr+j < sb: o_q[j] = dat[(base+rd_ptr+j) mod 32].
  - Else: o_q[j] = i_ls_signed & s.
- dat does not shift during readout.
- i_load and dat_en together: the load wins.

Byte selects:
- o_sel = (byte: 4'b0001, half: 4'b0011, word: 4'b1111) << i_lsb, truncated to 4 bits.

Test Plan:
- W=1, word store: rs2 = 0xA5A5_1234, i_lsb = 0, byte_valid = 1 for 32 init steps -> o_dat = 0xA5A51234; o_sel = 4'b1111.
- W=4, shift: operand low bits = 13, 8 init steps then execute -> o_sh_done deasserted for 3 steps, asserted on step 4 with o_sh_rem = 1; o_sh_done_r asserted one cycle after o_sh_done.
- W=1, signed byte load: i_dat = 0x0000_8000, i_lsb = 1, size = 0, signed = 1 -> o_q = 0 for steps 0-6, then 1 for steps 7-31 (result 0xFFFFFF80).
- W=2, unsigned half load: i_dat = 0xBEEF_0000, i_lsb = 2 -> serialised result 0x0000BEEF; o_sel = 4'b1100.
- Reset during the 5th execute step of a shift (i_rst_n low asynchronously mid-cycle) -> o_dat, o_sh_done_r and o_sh_rem are 0 immediately; shamt = 0 on the next op gives o_sh_done on the first execute step.
- i_load and dat_en in the same cycle -> dat = i_dat; the rd_ptr readout restarts at 0.
